// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard logic.
// Holds the controller state enum, register index type and default stall counts.
package mips_pipe_pkg;

    typedef enum logic {
        IDLE,
        STALL
    } state_t;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    localparam int DEF_BR_ALU_STALLS  = 1;
    localparam int DEF_BR_LOAD_STALLS = 2;
    localparam int DEF_LU_STALLS      = 1;

    // Stall counts are 1..3, so two bits hold both N and the remaining count.
    typedef logic [1:0] stall_n_t;

    typedef enum logic [1:0] {
        HZ_NONE,
        HZ_BR_LOAD,
        HZ_BR_ALU,
        HZ_LOAD_USE
    } hz_class_t;

endpackage

// File: rtl/hazard_match.sv
// Combinational ID-vs-EX register comparator and hazard classifier.
// In: ID branch flag, rs/rt usage and indices, EX write/load/dest. Out: match_rs/rt, class, N.
module hazard_match
    import mips_pipe_pkg::*;
#(
    parameter int BR_ALU_STALLS  = DEF_BR_ALU_STALLS,
    parameter int BR_LOAD_STALLS = DEF_BR_LOAD_STALLS,
    parameter int LU_STALLS      = DEF_LU_STALLS
) (
    input  logic      branch_id,
    input  logic      use_rs_id,
    input  logic      use_rt_id,
    input  reg_idx_t  rs_id,
    input  reg_idx_t  rt_id,
    input  logic      reg_write_idex,
    input  logic      mem_read_idex,
    input  reg_idx_t  writereg_idex,
    output logic      match_rs,
    output logic      match_rt,
    output hz_class_t hz_class,
    output stall_n_t  hz_n
);

    localparam stall_n_t N_BR_LOAD = stall_n_t'(BR_LOAD_STALLS);
    localparam stall_n_t N_BR_ALU  = stall_n_t'(BR_ALU_STALLS);
    localparam stall_n_t N_LU      = stall_n_t'(LU_STALLS);

    logic any_match;

    assign match_rs  = use_rs_id && (rs_id == writereg_idex)
                       && (writereg_idex != REG_ZERO);
    assign match_rt  = use_rt_id && (rt_id == writereg_idex)
                       && (writereg_idex != REG_ZERO);
    assign any_match = match_rs || match_rt;

    // The three classes split on branch_id/mem_read_idex and are
    // therefore mutually exclusive.
    always_comb begin
        hz_class = HZ_NONE;
        hz_n     = '0;
        unique case (1'b1)
            branch_id && mem_read_idex && any_match: begin
                hz_class = HZ_BR_LOAD;
                hz_n     = N_BR_LOAD;
            end
            branch_id && reg_write_idex && !mem_read_idex && any_match: begin
                hz_class = HZ_BR_ALU;
                hz_n     = N_BR_ALU;
            end
            !branch_id && mem_read_idex && any_match: begin
                hz_class = HZ_LOAD_USE;
                hz_n     = N_LU;
            end
            default: begin
                hz_class = HZ_NONE;
                hz_n     = '0;
            end
        endcase
    end

endmodule

// File: rtl/branch_hazard_controller.sv
// ID-stage stall/flush sequencer: load-use and unresolved branch-operand stalls, taken-branch/jump flush, global hold.
// Ports: clk, rst_n, hold, ID/EX hazard inputs; out pc_write, ifid_write, ifid_flush, idex_bubble, stalled, stall_cnt, flush_cnt (counters live only with HAZARD_PERF_CNT_EN).
module branch_hazard_controller
    import mips_pipe_pkg::*;
#(
    parameter int BR_ALU_STALLS  = DEF_BR_ALU_STALLS,
    parameter int BR_LOAD_STALLS = DEF_BR_LOAD_STALLS,
    parameter int LU_STALLS      = DEF_LU_STALLS,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             branch_id,
    input  logic             jump_id,
    input  logic             branch_taken_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic             reg_write_idex,
    input  logic             mem_read_idex,
    input  logic [4:0]       writereg_idex,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             stalled,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    state_t    state_q, state_d;
    stall_n_t  rem_q, rem_d;
    logic      match_rs, match_rt;
    hz_class_t hz_class;
    stall_n_t  hz_n;
    logic      hazard;

    hazard_match #(
        .BR_ALU_STALLS  (BR_ALU_STALLS),
        .BR_LOAD_STALLS (BR_LOAD_STALLS),
        .LU_STALLS      (LU_STALLS)
    ) u_match (
        .branch_id      (branch_id),
        .use_rs_id      (use_rs_id),
        .use_rt_id      (use_rt_id),
        .rs_id          (rs_id),
        .rt_id          (rt_id),
        .reg_write_idex (reg_write_idex),
        .mem_read_idex  (mem_read_idex),
        .writereg_idex  (writereg_idex),
        .match_rs       (match_rs),
        .match_rt       (match_rt),
        .hz_class       (hz_class),
        .hz_n           (hz_n)
    );

    assign hazard = (hz_class != HZ_NONE) && (match_rs || match_rt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stalled     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hold) begin
                    idex_bubble = 1'b0;
                end else if (hazard) begin
                    idex_bubble = 1'b1;
                    // The hazard cycle itself is the first stall cycle.
                    if (hz_n > 2'd1) begin
                        state_d = STALL;
                        rem_d   = hz_n - 2'd1;
                    end
                end else begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    ifid_flush = jump_id || (branch_id && branch_taken_id);
                end
            end
            STALL: begin
                stalled     = 1'b1;
                idex_bubble = !hold;
                if (!hold) begin
                    if (rem_q <= 2'd1) begin
                        state_d = IDLE;
                        rem_d   = '0;
                    end else begin
                        rem_d = rem_q - 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                rem_d   = '0;
            end
        endcase
        // Reset forces a safe bubble regardless of registered state.
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b1;
            stalled     = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!hold && !pc_write) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (ifid_flush) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: doc/branch_hazard_controller.md
Name: branch_hazard_controller

Overview:
- Sequences the ID-stage stall and flush controls for the 5-stage MIPS pipeline, alongside the ID-stage branch comparator and its forwarding muxes.
- Detects two hazards in ID:
  - load-use hazards;
  - branch-operand hazards that ID-stage forwarding cannot resolve.
- Holds PC and IF/ID for a parameterised number of cycles and injects bubbles into ID/EX.
- Flushes IF/ID on a taken branch or jump, and honours a global memory hold.

Parameters:
- BR_ALU_STALLS, 1, stall cycles when a branch operand is produced by an ALU op currently in EX (legal 1..3).
- BR_LOAD_STALLS, 2, stall cycles when a branch operand is produced by a load currently in EX (legal 1..3).
- LU_STALLS, 1, stall cycles for a non-branch load-use hazard (legal 1..3).
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hold  in  1  global freeze request (memory not ready).
- branch_id  in  1  ID instruction is a conditional branch.
- jump_id  in  1  ID instruction is a jump.
- branch_taken_id  in  1  ID comparator result (valid when branch_id=1).
- use_rs_id  in  1  ID instruction reads rs.
- use_rt_id  in  1  ID instruction reads rt.
- rs_id  in  5  ID source register rs.
- rt_id  in  5  ID source register rt.
- reg_write_idex  in  1  EX instruction writes a register.
- mem_read_idex  in  1  EX instruction is a load.
- writereg_idex  in  5  EX destination register.
- pc_write  out  1  PC enable.
- ifid_write  out  1  IF/ID enable.
- ifid_flush  out  1  zero IF/ID on next edge.
- idex_bubble  out  1  load NOP into ID/EX on next edge.
- stalled  out  1  controller is in STALL state.
- stall_cnt  out  CNT_W  total stall cycles (feature-dependent).
- flush_cnt  out  CNT_W  total flushes (feature-dependent).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, remaining-stall counter=0, perf counters=0.
  - Outputs while in reset: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1, stalled=0.
- Match definition: match_rs = use_rs_id && rs_id==writereg_idex && writereg_idex!=0. match_rt is defined the same way using use_rt_id and rt_id.
- Hazard classes, evaluated only in IDLE; priority order is:
  1. branch_id && mem_read_idex && (match_rs||match_rt) → N = BR_LOAD_STALLS.
  2. branch_id && reg_write_idex && !mem_read_idex && match → N = BR_ALU_STALLS.
  3. !branch_id && mem_read_idex && match → N = LU_STALLS.
- States:
  - IDLE:
    - hold=1: pc_write=0, ifid_write=0, idex_bubble=0, no transition.
    - Hazard of class N: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, same cycle (combinational). If N>1, go to STALL with remaining=N-1; if N=1, stay in IDLE.
    - No hazard: pc_write=1, ifid_write=1, idex_bubble=0. ifid_flush = jump_id || (branch_id && branch_taken_id).
  - STALL:
    - pc_write=0, ifid_write=0, idex_bubble=1, stalled=1; hazard inputs are ignored.
    - Each non-hold edge decrements remaining; on reaching 0, go to IDLE and re-evaluate there.
    - hold=1: remaining and state frozen, idex_bubble=0.
- Simultaneous events:
  - Hazard plus taken branch/jump: the stall wins and ifid_flush=0; the flush happens on the resolving cycle.
  - hold wins over everything, and no flush is issued while hold=1.
- Register 0 never causes a hazard.
- Mid-operation reset aborts STALL immediately and returns to IDLE.
- All outputs are combinational from state and inputs; there is no added latency.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every non-hold cycle with pc_write=0.
  - flush_cnt increments on every cycle with ifid_flush=1.
  - Both wrap modulo 2^CNT_W and are cleared only by reset.
- Undefined: stall_cnt and flush_cnt are tied to 0, and no counter flops are synthesised.

Decomposition:
- Shared package mips_pipe_pkg holds:
  - state enum {IDLE, STALL};
  - the 5-bit register-index type;
  - REG_ZERO constant;
  - default stall-count constants.
- One sub-module, hazard_match: the combinational comparator producing match_rs, match_rt and the hazard class plus N. It is instantiated once.

Test Plan:
- Load-use:
  - Stimulus: lw $2 in EX (mem_read_idex=1, writereg_idex=2); add using rs=2 in ID.
  - Expect: exactly 1 cycle with pc_write=0, idex_bubble=1; then pc_write=1.
- Branch after ALU:
  - Stimulus: EX writes $5 via ALU; beq with rt=5 in ID.
  - Expect: 1 stall cycle; then the branch resolves with taken=1, giving ifid_flush=1 for one cycle.
- Branch after load (default parameters):
  - Stimulus: EX is lw $7; beq rs=7.
  - Expect: 2 stall cycles with stalled=1 on the second; ifid_flush=0 throughout the stall.
- Register-zero immunity:
  - Stimulus: EX lw $0; ID uses rs=0.
  - Expect: no stall; pc_write=1.
- Hold and mid-stall reset:
  - Stimulus: enter a branch-after-load STALL; assert hold for 3 cycles.
  - Expect: stall length is extended by 3 and idex_bubble=0 during the hold.
  - Stimulus: pulse rst_n=0 mid-STALL.
  - Expect: IDLE immediately.
- Counters (HAZARD_PERF_CNT_EN defined):
  - Stimulus: 3 load-use hazards and 2 jumps.
  - Expect: stall_cnt=3, flush_cnt=2.
  - With the macro undefined, both outputs read 0.
